// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - pipelined radix-4 sign-magnitude multiplier with tag, stall and flush
module mul_pipe #(
  parameter int W     = 30,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W:0]       a,
  input  logic [W:0]       b,
  input  logic [TAG_W-1:0] tag,
  input  logic             stall,
  input  logic             flush,
  output logic             stop,
  output logic [2*W-1:0]   out,
  output logic             sign,
  output logic [TAG_W-1:0] tag_out
);

  // R radix-4 rows reduced by a D-level binary tree; results emerge D+1 cycles after issue.
  localparam int R  = (W + 1) / 2;
  localparam int D  = $clog2(R);
  localparam int PW = 2 * W;

  // Every row slot is kept at full product width. Slots past a level's live row
  // count stay zero, so pairing them in is harmless and no carry is ever lost.
  logic [PW-1:0]    row_q [0:D][0:R-1];
  logic [PW-1:0]    row_d [0:D][0:R-1];
  logic [D:0]       valid_q, valid_d;
  logic [D:0]       sgn_q, sgn_d;
  logic [TAG_W-1:0] tag_q [0:D];
  logic [TAG_W-1:0] tag_d [0:D];

  logic             adv;
  logic [W+1:0]     a_ext;
  logic [2*R-1:0]   b_pad;

  // A flush always moves the pipe, even when stall is also asserted.
  assign adv   = flush | ~stall;
  assign a_ext = {2'b00, a[W-1:0]};

  // Zero-pad the b magnitude to a whole number of bit pairs.
  always_comb begin
    b_pad        = '0;
    b_pad[W-1:0] = b[W-1:0];
  end

  // Partial-product selection for stage 0, then one pairwise reduction per tree level.
  always_comb begin
    for (int l = 0; l <= D; l++) begin
      for (int k = 0; k < R; k++) begin
        row_d[l][k] = '0;
      end
    end
    for (int i = 0; i < R; i++) begin
      case (b_pad[2*i +: 2])
        2'b01:   row_d[0][i][W+1:0] = a_ext;
        2'b10:   row_d[0][i][W+1:0] = a_ext << 1;
        2'b11:   row_d[0][i][W+1:0] = a_ext + (a_ext << 1);
        default: row_d[0][i][W+1:0] = '0;
      endcase
    end
    // Adjacent rows at level l-1 differ in weight by 2^(2^l).
    for (int l = 1; l <= D; l++) begin
      for (int k = 0; k < R / 2; k++) begin
        row_d[l][k] = row_q[l-1][2*k] + (row_q[l-1][2*k+1] << (1 << l));
      end
      if (R % 2 == 1) begin
        row_d[l][R/2] = row_q[l-1][R-1];
      end
    end
  end

  // Sign and tag ride alongside the datapath one stage at a time.
  always_comb begin
    sgn_d    = '0;
    sgn_d[0] = a[W] ^ b[W];
    tag_d[0] = tag;
    for (int l = 1; l <= D; l++) begin
      sgn_d[l] = sgn_q[l-1];
      tag_d[l] = tag_q[l-1];
    end
  end

  // Valid bits: shift when advancing, clear downstream stages on flush, always capture start when advancing.
  always_comb begin
    valid_d = valid_q;
    if (adv) begin
      valid_d[0] = start;
      for (int l = 1; l <= D; l++) begin
        valid_d[l] = valid_q[l-1] & ~flush;
      end
    end
  end

  // Pipeline registers: valid bits always update, data only moves when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sgn_q   <= '0;
      for (int l = 0; l <= D; l++) begin
        tag_q[l] <= '0;
        for (int k = 0; k < R; k++) begin
          row_q[l][k] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      if (adv) begin
        row_q <= row_d;
        sgn_q <= sgn_d;
        tag_q <= tag_d;
      end
    end
  end

  // Outputs come straight from the last stage, forced to zero when it holds no result.
  assign stop    = valid_q[D];
  assign out     = valid_q[D] ? row_q[D][0] : '0;
  assign sign    = valid_q[D] & sgn_q[D];
  assign tag_out = valid_q[D] ? tag_q[D] : '0;

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - self-checking bench for mul_pipe at W=30 and W=7
module tb_mul_pipe;

  localparam int D0 = 4;   // W=30: R=15 rows, 4 tree levels
  localparam int D1 = 2;   // W=7:  R=4 rows, 2 tree levels

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        start0, start1;
  logic [30:0] a0, b0;
  logic [7:0]  a1, b1;
  logic [3:0]  tag0, tag1;
  logic        stop0, stop1, sign0, sign1;
  logic [59:0] out0;
  logic [13:0] out1;
  logic [3:0]  tago0, tago1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          id;
    logic [59:0] p;
    logic        s;
    logic [3:0]  t;
    int          rem;
  } op_t;

  op_t mq[$];

  always #5 clk = ~clk;

  mul_pipe #(.W(30), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .tag(tag0),
    .stall(stall), .flush(flush), .stop(stop0), .out(out0), .sign(sign0), .tag_out(tago0)
  );

  mul_pipe #(.W(7), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .tag(tag1),
    .stall(stall), .flush(flush), .stop(stop1), .out(out1), .sign(sign1), .tag_out(tago1)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: each accepted operation waits its depth in advancing edges, then is presented.
  task automatic model_edge();
    op_t nq[$];
    op_t o;
    longint unsigned x, y;
    if (!rst_n) begin
      mq.delete();
    end else if (flush || !stall) begin
      if (!flush) begin
        foreach (mq[i]) begin
          if (mq[i].rem > 0) begin
            o = mq[i];
            o.rem = o.rem - 1;
            nq.push_back(o);
          end
        end
      end
      mq = nq;
      if (start0) begin
        x = 64'(a0[29:0]);
        y = 64'(b0[29:0]);
        o.id = 0; o.p = 60'(x * y); o.s = a0[30] ^ b0[30]; o.t = tag0; o.rem = D0;
        mq.push_back(o);
      end
      if (start1) begin
        x = 64'(a1[6:0]);
        y = 64'(b1[6:0]);
        o.id = 1; o.p = 60'(x * y); o.s = a1[7] ^ b1[7]; o.t = tag1; o.rem = D1;
        mq.push_back(o);
      end
    end
  endtask

  task automatic check_all();
    logic [59:0] eo [2];
    logic        es [2];
    logic        ev [2];
    logic [3:0]  et [2];
    for (int d = 0; d < 2; d++) begin
      eo[d] = '0; es[d] = 1'b0; ev[d] = 1'b0; et[d] = '0;
    end
    foreach (mq[i]) begin
      if (mq[i].rem == 0) begin
        ev[mq[i].id] = 1'b1;
        eo[mq[i].id] = mq[i].p;
        es[mq[i].id] = mq[i].s;
        et[mq[i].id] = mq[i].t;
      end
    end
    check("stop0", 64'(stop0), 64'(ev[0]));
    check("out0",  64'(out0),  64'(eo[0]));
    check("sign0", 64'(sign0), 64'(es[0]));
    check("tag0",  64'(tago0), 64'(et[0]));
    check("stop1", 64'(stop1), 64'(ev[1]));
    check("out1",  64'(out1),  64'(eo[1]));
    check("sign1", 64'(sign1), 64'(es[1]));
    check("tag1",  64'(tago1), 64'(et[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic issue0(input logic sa, input logic [29:0] ma, input logic sb, input logic [29:0] mb,
                        input logic [3:0] t);
    start0 = 1'b1;
    a0     = {sa, ma};
    b0     = {sb, mb};
    tag0   = t;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; tag0 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0; tag1 = '0;
    #1 rst_n = 1'b0;
    mq.delete();
    #1 check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic product: +3 * -5, tag 2, five cycles later
    issue0(1'b0, 30'd3, 1'b1, 30'd5, 4'd2);
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("basic_stop", 64'(stop0), 64'd1);
    check("basic_out",  64'(out0),  64'd15);
    check("basic_sign", 64'(sign0), 64'd1);
    check("basic_tag",  64'(tago0), 64'd2);
    repeat (2) tick();

    // Maximum magnitudes
    issue0(1'b0, 30'h3FFF_FFFF, 1'b0, 30'h3FFF_FFFF, 4'd1);
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("max_out",  64'(out0),  64'h0FFF_FFFF_8000_0001);
    check("max_sign", 64'(sign0), 64'd0);
    tick();

    // Back-to-back issue
    issue0(1'b0, 30'd1, 1'b0, 30'd1, 4'd0);    tick();
    issue0(1'b0, 30'd2, 1'b0, 30'd3, 4'd1);    tick();
    issue0(1'b0, 30'd1000, 1'b0, 30'd1000, 4'd2); tick();
    start0 = 1'b0;
    repeat (2) tick();
    check("b2b_out0", 64'(out0), 64'd1);
    check("b2b_tag0", 64'(tago0), 64'd0);
    tick();
    check("b2b_out1", 64'(out0), 64'd6);
    check("b2b_tag1", 64'(tago0), 64'd1);
    tick();
    check("b2b_out2", 64'(out0), 64'd1000000);
    check("b2b_tag2", 64'(tago0), 64'd2);
    tick();
    check("b2b_idle", 64'(stop0), 64'd0);

    // Minus zero keeps its sign
    issue0(1'b1, 30'd0, 1'b0, 30'd7, 4'd3);
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("mz_stop", 64'(stop0), 64'd1);
    check("mz_out",  64'(out0),  64'd0);
    check("mz_sign", 64'(sign0), 64'd1);

    // Two-cycle stall at n+2 with a start offered during the stall
    issue0(1'b0, 30'd12, 1'b1, 30'd34, 4'd5);
    tick();
    start0 = 1'b0;
    tick();
    stall = 1'b1;
    issue0(1'b0, 30'd99, 1'b0, 30'd99, 4'd9);
    repeat (2) tick();
    stall = 1'b0; start0 = 1'b0;
    repeat (2) tick();
    check("stall_early", 64'(stop0), 64'd0);
    tick();
    check("stall_out", 64'(out0),  64'd408);
    check("stall_tag", 64'(tago0), 64'd5);
    repeat (2) tick();

    // Flush at n+2 with a new start in the flush cycle
    issue0(1'b0, 30'd5, 1'b0, 30'd6, 4'd6);
    tick();
    start0 = 1'b0;
    tick();
    flush = 1'b1;
    issue0(1'b0, 30'd7, 1'b0, 30'd8, 4'd7);
    tick();
    flush = 1'b0; start0 = 1'b0;
    repeat (4) tick();
    check("flush_out", 64'(out0),  64'd56);
    check("flush_tag", 64'(tago0), 64'd7);
    tick();

    // Reset while three operations are in flight
    issue0(1'b0, 30'd11, 1'b0, 30'd13, 4'd1); tick();
    issue0(1'b1, 30'd17, 1'b0, 30'd19, 4'd2); tick();
    issue0(1'b0, 30'd23, 1'b1, 30'd29, 4'd3); tick();
    start0 = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check("rst_stop", 64'(stop0), 64'd0);
    check("rst_out",  64'(out0),  64'd0);
    check_all();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Odd width: 127 * 127
    start1 = 1'b1; a1 = {1'b0, 7'd127}; b1 = {1'b0, 7'd127}; tag1 = 4'd9;
    tick();
    start1 = 1'b0;
    repeat (2) tick();
    check("w7_out", 64'(out1), 64'd16129);
    check("w7_tag", 64'(tago1), 64'd9);
    tick();

    // Random traffic on both widths with random stall and flush
    for (int n = 0; n < 500; n++) begin
      start0 = 1'($urandom);
      start1 = 1'($urandom);
      a0 = {1'($urandom), ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : 30'($urandom)};
      b0 = {1'($urandom), ($urandom_range(0, 7) == 0) ? 30'd0 : 30'($urandom)};
      a1 = 8'($urandom);
      b1 = 8'($urandom);
      tag0 = 4'($urandom);
      tag1 = 4'($urandom);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 5);
      tick();
    end
    start0 = 1'b0; start1 = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
